// File: rtl/aqp_audio_pkg.sv
// Shared constants, types and arithmetic helpers for the audio mixer.
//   AUDIO_MID      : offset-binary midscale (silence) driven to the DAC
//   S16_MAX/S16_MIN: saturation limits of the 16-bit signed mix
//   VOL_SHIFT      : gain is vol / 2^VOL_SHIFT
//   MIX_W/SCALED_W : mix adder width and per-source scaled width
package aqp_audio_pkg;

    localparam int MIX_W     = 21;
    localparam int SCALED_W  = 20;
    localparam int VOL_SHIFT = 3;

    localparam logic [15:0]              AUDIO_MID = 16'h8000;
    localparam logic signed [MIX_W-1:0]  S16_MAX   = 21'sd32767;
    localparam logic signed [MIX_W-1:0]  S16_MIN   = -21'sd32768;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } stereo_t;

    // (sample * vol) >>> VOL_SHIFT; vol is an unsigned 0..15 gain code.
    function automatic logic signed [SCALED_W-1:0] scale_vol(
        input logic signed [15:0] s,
        input logic [3:0]         vol
    );
        logic signed [MIX_W-1:0] s_ext;
        logic signed [MIX_W-1:0] v_ext;
        logic signed [MIX_W-1:0] prod;
        s_ext = MIX_W'(s);
        v_ext = $signed(MIX_W'(vol));
        prod  = s_ext * v_ext;
        return SCALED_W'(prod >>> VOL_SHIFT);
    endfunction

    // Clamp to the signed 16-bit range, then flip the MSB for the DAC.
    function automatic logic [15:0] sat_offset(input logic signed [MIX_W-1:0] sum);
        logic [15:0] s16;
        if (sum > S16_MAX) begin
            s16 = 16'h7FFF;
        end else if (sum < S16_MIN) begin
            s16 = 16'h8000;
        end else begin
            s16 = sum[15:0];
        end
        return s16 ^ AUDIO_MID;
    endfunction

endpackage

// File: rtl/aqp_audio_mixer_if.sv
// CPU/PSG-facing and DAC-facing signal bundle of the audio mixer.
//   master: sample writer / PSG / volume registers / DAC consumer side
//   slave : the mixer itself
interface aqp_audio_mixer_if #(
    parameter int FIFO_AW = 4
);
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [15:0]       psg_data;
    logic [3:0]        vol_pcm;
    logic [3:0]        vol_psg;
    logic              clr_flags;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic              underrun;
    logic              overflow;
    logic              next_sample;
    logic [15:0]       left_data;
    logic [15:0]       right_data;

    modport master (
        output wr_en, wr_data, psg_data, vol_pcm, vol_psg, clr_flags,
        input  fifo_full, fifo_empty, fifo_count, underrun, overflow,
               next_sample, left_data, right_data
    );

    modport slave (
        input  wr_en, wr_data, psg_data, vol_pcm, vol_psg, clr_flags,
        output fifo_full, fifo_empty, fifo_count, underrun, overflow,
               next_sample, left_data, right_data
    );
endinterface

// File: rtl/aqp_audio_fifo.sv
// Single-clock synchronous FIFO with registered read data.
//   push/push_data : write request; dropped when full (push_drop pulses)
//   pop            : read request; when empty pop_data loads 0 (pop_under pulses)
//   pop_data       : registered read word, updated only on pop
//   count/full/empty: occupancy, all derived from the registered count
// Full/empty decisions use the state before the current edge, so a push
// and pop in the same cycle are judged independently.
module aqp_audio_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             push_drop,
    output logic             pop_under
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign push_drop = push & full;
    assign pop_under = pop & empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (pop) begin
                pop_data <= pop_ok ? mem[rd_ptr] : '0;
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/aqp_audio_mixer.sv
// Sample-rate divider, PCM FIFO and stereo mixer feeding the PWM DAC.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : PCM writes, PSG sample, volumes, flag clear in;
//                  FIFO status, sticky flags, next_sample strobe and
//                  offset-binary left/right words out
// Pipeline: tick (T) -> pop + PSG capture (T+1) -> scale (T+2) -> mix,
// saturate and strobe (T+3).
module aqp_audio_mixer
    import aqp_audio_pkg::*;
#(
    parameter int SAMPLE_DIV = 1024,
    parameter int FIFO_AW    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    aqp_audio_mixer_if.slave bus
);
    localparam int               CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0]           div_cnt;
    logic                       tick;
    stereo_t                    pcm_q;
    logic [15:0]                psg_q;
    logic                       v1;
    logic                       v2;
    logic signed [SCALED_W-1:0] pcm_l_s;
    logic signed [SCALED_W-1:0] pcm_r_s;
    logic signed [SCALED_W-1:0] psg_s;
    logic [15:0]                left_q;
    logic [15:0]                right_q;
    logic                       next_q;
    logic                       underrun_q;
    logic                       overflow_q;
    logic [FIFO_AW:0]           fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push_drop;
    logic                       pop_under;

    // tick is registered so the first one lands SAMPLE_DIV clocks after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
        end
    end

    // The FIFO's registered read word is the stage-1 PCM register.
    aqp_audio_fifo #(
        .WIDTH (32),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (tick),
        .pop_data  (pcm_q),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (push_drop),
        .pop_under (pop_under)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psg_q   <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            pcm_l_s <= '0;
            pcm_r_s <= '0;
            psg_s   <= '0;
            left_q  <= AUDIO_MID;
            right_q <= AUDIO_MID;
            next_q  <= 1'b0;
        end else begin
            v1 <= tick;
            if (tick) begin
                psg_q <= bus.psg_data;
            end
            v2 <= v1;
            if (v1) begin
                pcm_l_s <= scale_vol(pcm_q.left,  bus.vol_pcm);
                pcm_r_s <= scale_vol(pcm_q.right, bus.vol_pcm);
                psg_s   <= scale_vol(psg_q,       bus.vol_psg);
            end
            next_q <= v2;
            if (v2) begin
                left_q  <= sat_offset(MIX_W'(pcm_l_s) + MIX_W'(psg_s));
                right_q <= sat_offset(MIX_W'(pcm_r_s) + MIX_W'(psg_s));
            end
        end
    end

    // A clear wins over a set landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.clr_flags) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (pop_under) begin
                underrun_q <= 1'b1;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.fifo_full   = fifo_full;
    assign bus.fifo_empty  = fifo_empty;
    assign bus.fifo_count  = fifo_count;
    assign bus.underrun    = underrun_q;
    assign bus.overflow    = overflow_q;
    assign bus.next_sample = next_q;
    assign bus.left_data   = left_q;
    assign bus.right_data  = right_q;
endmodule

// File: tb/tb_aqp_audio_mixer.sv
// Scoreboard bench for aqp_audio_mixer with SAMPLE_DIV=8, FIFO_AW=4.
// Stimulus pushes words tagged with hand-computed DAC outputs; a queue
// model of FIFO order turns each tick into an expected strobe, and a
// monitor compares every next_sample against it.
module tb_aqp_audio_mixer;
    localparam int DIV = 8;
    localparam int AW  = 4;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc;
    int          tests   = 0;
    int          fails   = 0;
    exp_t        sb[$];
    pair_t       model_q[$];
    logic [15:0] exp_l   = 16'h0;
    logic [15:0] exp_r   = 16'h0;
    logic [15:0] sil_l   = 16'h8000;
    logic [15:0] sil_r   = 16'h8000;

    always #5 clk = ~clk;

    aqp_audio_mixer_if #(.FIFO_AW(AW)) bus ();

    aqp_audio_mixer #(
        .SAMPLE_DIV (DIV),
        .FIFO_AW    (AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // FIFO-order model: on a tick cycle pop (or silence), then accept a push
    // if the queue was not full before this edge.
    always @(posedge clk) begin
        bit    was_full;
        pair_t p;
        if (reset_n) begin
            was_full = (model_q.size() == 16);
            if (cyc > 0 && (cyc % DIV) == 0) begin
                if (model_q.size() == 0) begin
                    sb.push_back('{sil_l, sil_r, cyc + 3});
                end else begin
                    p = model_q.pop_front();
                    sb.push_back('{p.l, p.r, cyc + 3});
                end
            end
            if (bus.wr_en && !was_full) model_q.push_back('{exp_l, exp_r});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL strobe_missing: no strobe seen, required one at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (bus.next_sample) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL strobe_unexpected: strobe at cycle %0d left=%h right=%h, required none",
                         cyc, bus.left_data, bus.right_data);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || bus.left_data !== e.l || bus.right_data !== e.r) begin
                    fails++;
                    $display("FAIL strobe_data: got cycle %0d left=%h right=%h, required cycle %0d left=%h right=%h",
                             cyc, bus.left_data, bus.right_data, e.cyc, e.l, e.r);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic at_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            tests++;
            fails++;
            $display("FAIL at_cyc: got cycle %0d, required %0d", cyc, n);
        end
    endtask

    task automatic set_push(input logic [15:0] l, input logic [15:0] r,
                            input logic [15:0] el, input logic [15:0] er);
        bus.wr_en   = 1'b1;
        bus.wr_data = {l, r};
        exp_l       = el;
        exp_r       = er;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_left"},  32'(bus.left_data),   32'h8000);
        chk({tag, "_right"}, 32'(bus.right_data),  32'h8000);
        chk({tag, "_strobe"}, 32'(bus.next_sample), 32'h0);
        chk({tag, "_count"}, 32'(bus.fifo_count),  32'h0);
        chk({tag, "_empty"}, 32'(bus.fifo_empty),  32'h1);
        chk({tag, "_flags"}, 32'({bus.underrun, bus.overflow}), 32'h0);
    endtask

    initial begin
        logic [15:0] v;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.psg_data  = '0;
        bus.vol_pcm   = 4'd8;
        bus.vol_psg   = 4'd0;
        bus.clr_flags = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        #1 reset_n = 1'b1;
        @(negedge clk);

        // silent cadence: strobes at 11 and 19
        at_cyc(10);
        chk("underrun_first", 32'(bus.underrun), 32'h1);
        at_cyc(17);
        bus.clr_flags = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
        chk("underrun_clr", 32'(bus.underrun), 32'h0);

        // unity PCM, popped at tick 24, strobe 27
        set_push(16'h1000, 16'hF000, 16'h9000, 16'h7000);
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("unity_count1", 32'(bus.fifo_count), 32'd1);
        at_cyc(25);
        chk("unity_count0", 32'(bus.fifo_count), 32'd0);
        chk("unity_no_underrun", 32'(bus.underrun), 32'h0);

        // saturation, popped at tick 32, strobe 35
        at_cyc(26);
        bus.vol_pcm  = 4'd15;
        bus.psg_data = 16'h4000;
        bus.vol_psg  = 4'd8;
        sil_l = 16'hC000;
        sil_r = 16'hC000;
        set_push(16'h7000, 16'h9000, 16'hFFFF, 16'h0000);
        @(negedge clk);
        bus.wr_en = 1'b0;
        at_cyc(36);
        bus.vol_pcm  = 4'd8;
        bus.psg_data = 16'h0000;
        bus.vol_psg  = 4'd0;
        sil_l = 16'h8000;
        sil_r = 16'h8000;

        // back-to-back pushes from cycle 41; ticks 48 and 56 each pop one,
        // so the FIFO reaches 16 after the 18th push and the 19th is dropped
        for (int i = 1; i <= 19; i++) begin
            at_cyc(40 + i);
            if (i == 19) begin
                chk("ovf_full", 32'(bus.fifo_full), 32'h1);
                chk("ovf_count16", 32'(bus.fifo_count), 32'd16);
                chk("ovf_not_yet", 32'(bus.overflow), 32'h0);
            end
            v = 16'(i * 256);
            set_push(v, 16'h0000 - v, 16'h8000 + v, 16'h8000 - v);
        end
        at_cyc(60);
        bus.wr_en = 1'b0;
        chk("ovf_set", 32'(bus.overflow), 32'h1);
        chk("ovf_count_hold", 32'(bus.fifo_count), 32'd16);
        at_cyc(61);
        bus.clr_flags = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'h0);

        // push on a tick with the FIFO full
        at_cyc(64);
        set_push(16'h1400, 16'hEC00, 16'h9400, 16'h6C00);
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("tickfull_ovf", 32'(bus.overflow), 32'h1);
        chk("tickfull_count15", 32'(bus.fifo_count), 32'd15);
        chk("tickfull_notfull", 32'(bus.fifo_full), 32'h0);

        // drain completes at tick 184; push on tick 192 with FIFO empty
        at_cyc(190);
        bus.clr_flags = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
        chk("drain_empty", 32'(bus.fifo_empty), 32'h1);
        chk("drain_flags", 32'({bus.underrun, bus.overflow}), 32'h0);
        at_cyc(192);
        set_push(16'h2000, 16'hE000, 16'hA000, 16'h6000);
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("tickempty_underrun", 32'(bus.underrun), 32'h1);
        chk("tickempty_count1", 32'(bus.fifo_count), 32'd1);

        // queue data, then reset one clock after tick 208
        at_cyc(204);
        set_push(16'h0400, 16'h0400, 16'h8400, 16'h8400);
        @(negedge clk);
        set_push(16'h0800, 16'h0800, 16'h8800, 16'h8800);
        @(negedge clk);
        bus.wr_en = 1'b0;
        at_cyc(209);
        chk("prereset_count", 32'(bus.fifo_count), 32'd1);
        #1 reset_n = 1'b0;
        sb.delete();
        model_q.delete();
        repeat (3) @(negedge clk);
        chk_reset_state("midrst");
        #1 reset_n = 1'b1;
        @(negedge clk);
        at_cyc(10);
        chk("restart_underrun", 32'(bus.underrun), 32'h1);
        chk("restart_count", 32'(bus.fifo_count), 32'd0);
        at_cyc(21);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
